// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared opcode encodings, flag bit positions and shift-kind type
//             for the handshaked sequential ALU and its decoder.
//  Contents : OP_ADD..OP_ROR opcodes, FLAG_Z/FLAG_V/FLAG_N indices,
//             shift_kind_e (low two opcode bits of the shift group).
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Shift ops all have op[2]=1; op[1:0] selects the kind directly.
    typedef enum logic [1:0] {
        SK_SLL = 2'b00,
        SK_SRL = 2'b01,
        SK_SRA = 2'b10,
        SK_ROR = 2'b11
    } shift_kind_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_unit
//  Purpose  : Shift/rotate engine for alu_seq. Holds the working register and
//             the remaining-step counter.
//  Config   : ALU_BARREL_SHIFT_EN defined   -> single-cycle barrel shifter,
//                                              done follows start directly.
//             ALU_BARREL_SHIFT_EN undefined -> serial, one bit per cycle.
//  Ports    : clk, rst            clock / synchronous active-high reset
//             start               new shift offered (only while idle)
//             kind, data_in, amt  shift kind, operand, shift amount
//             busy                serial shift in progress
//             done                result valid this cycle (combinational)
//             result              shifted value, meaningful while done=1
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  shift_kind_e        kind,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] amt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [SHAMT_W-1:0] r_cnt;

    assign busy = (r_cnt != '0);

`ifdef ALU_BARREL_SHIFT_EN

    function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0]   d,
                                                input shift_kind_e        k,
                                                input logic [SHAMT_W-1:0] n);
        logic [2*WIDTH-1:0] rot;
        rot    = {d, d} >> n;
        barrel = d;
        case (k)
            SK_SLL:  barrel = d << n;
            SK_SRL:  barrel = d >> n;
            SK_SRA:  barrel = WIDTH'($signed(d) >>> n);
            SK_ROR:  barrel = rot[WIDTH-1:0];
            default: barrel = d;
        endcase
    endfunction

    // The counter never leaves zero in this build, so busy stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= '0;
        end
    end

    assign done   = start;
    assign result = barrel(data_in, kind, amt);

`else

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                              input shift_kind_e      k);
        step = d;
        case (k)
            SK_SLL:  step = {d[WIDTH-2:0], 1'b0};
            SK_SRL:  step = {1'b0, d[WIDTH-1:1]};
            SK_SRA:  step = {d[WIDTH-1], d[WIDTH-1:1]};
            SK_ROR:  step = {d[0], d[WIDTH-1:1]};
            default: step = d;
        endcase
    endfunction

    logic [WIDTH-1:0] r_work;
    shift_kind_e      r_kind;
    logic [WIDTH-1:0] w_step;

    assign w_step = step(r_work, r_kind);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_kind <= SK_SLL;
        end else if (start && (amt != '0)) begin
            r_cnt  <= amt;
            r_work <= data_in;
            r_kind <= kind;
        end else if (busy) begin
            r_cnt  <= r_cnt - c_CNT_ONE;
            r_work <= w_step;
        end
    end

    // A zero amount finishes immediately with the operand unchanged; otherwise
    // the step taken while cnt==1 is the last one and is presented directly.
    assign done   = (start && (amt == '0)) || (busy && (r_cnt == c_CNT_ONE));
    assign result = busy ? w_step : data_in;

`endif

endmodule : alu_shift_unit
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked, parametrised ALU: ADD/SUB/AND/OR and shifts/rotates
//             by a SHAMT_W-bit immediate. Result and Z/V/N flags are
//             registered and held until the consumer accepts them.
//  Config   : ALU_BARREL_SHIFT_EN selects the single-cycle barrel shifter in
//             alu_shift_unit; default is the serial shifter.
//  Ports    : clk, rst              clock / synchronous active-high reset
//             in_valid, in_ready    operation handshake
//             Data1, Data2, op, imm operands, opcode, shift amount
//             out_valid, out_ready  result handshake
//             Out, flag             registered result, flags {Z,V,N}
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   Data1,
    input  logic [WIDTH-1:0]   Data2,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Out,
    output logic [2:0]         flag
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic [2:0]       r_flag;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_sh_start;
    logic             w_sh_busy;
    logic             w_sh_done;
    logic [WIDTH-1:0] w_sh_result;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_v;
    logic [WIDTH-1:0] w_res;
    logic             w_res_v;
    logic [2:0]       w_flag_next;
    logic             w_load;

    assign in_ready   = (r_state == c_ST_IDLE);
    assign out_valid  = (r_state == c_ST_DONE);
    assign Out        = r_out;
    assign flag       = r_flag;

    assign w_accept   = in_ready && in_valid;
    assign w_is_shift = op[2];
    assign w_sh_start = w_accept && w_is_shift;

    alu_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (w_sh_start),
        .kind    (shift_kind_e'(op[1:0])),
        .data_in (Data1),
        .amt     (imm),
        .busy    (w_sh_busy),
        .done    (w_sh_done),
        .result  (w_sh_result)
    );

    // Add/sub/logic unit; carry out is dropped, V looks only at sign bits.
    always_comb begin
        w_alu   = '0;
        w_alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu   = Data1 + Data2;
                w_alu_v = (Data1[WIDTH-1] == Data2[WIDTH-1]) &&
                          (w_alu[WIDTH-1] != Data1[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu   = Data1 - Data2;
                w_alu_v = (Data1[WIDTH-1] != Data2[WIDTH-1]) &&
                          (w_alu[WIDTH-1] != Data1[WIDTH-1]);
            end
            OP_AND:  w_alu = Data1 & Data2;
            OP_OR:   w_alu = Data1 | Data2;
            default: begin
                w_alu   = '0;
                w_alu_v = 1'b0;
            end
        endcase
    end

    // Result selection: the ALU path only on an accepted non-shift op; any
    // shift completion (immediate or final serial step) uses the shifter.
    always_comb begin
        w_res   = w_sh_result;
        w_res_v = 1'b0;
        w_load  = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_accept && !w_is_shift) begin
                w_res   = w_alu;
                w_res_v = w_alu_v;
                w_load  = 1'b1;
            end else if (w_sh_start && w_sh_done) begin
                w_load  = 1'b1;
            end
        end else if (r_state == c_ST_SHIFT) begin
            w_load = w_sh_done;
        end
    end

    always_comb begin
        w_flag_next         = 3'b000;
        w_flag_next[FLAG_Z] = (w_res == '0);
        w_flag_next[FLAG_V] = w_res_v;
        w_flag_next[FLAG_N] = w_res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_out   <= '0;
            r_flag  <= 3'b000;
        end else begin
            if (w_load) begin
                r_out  <= w_res;
                r_flag <= w_flag_next;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_load) begin
                        r_state <= c_ST_DONE;
                    end else if (w_sh_start) begin
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state <= c_ST_DONE;
                    end else if (!w_sh_busy) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=16, SHAMT_W=4): directed
//             cases followed by randomized operations against a behavioural
//             model computed with plain integer arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Data1;
    logic [15:0] Data2;
    logic [2:0]  op;
    logic [3:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;
    logic [2:0]  flag;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(
        .WIDTH   (16),
        .SHAMT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data1     (Data1),
        .Data2     (Data2),
        .op        (op),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {Z,V,N, result} using signed integer arithmetic for overflow.
    function automatic logic [18:0] model(input logic [2:0] o,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [3:0] k);
        int          sa, sb, s;
        logic [15:0] r;
        logic        v;
        logic [31:0] x;
        sa = $signed(a);
        sb = $signed(b);
        v  = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin x = {16'h0, a} << k; r = x[15:0]; end
            3'd5: r = a >> k;
            3'd6: begin s = sa >>> k; r = s[15:0]; end
            default: begin x = {a, a} >> k; r = x[15:0]; end
        endcase
        model = {(r == 16'h0), v, r[15], r};
    endfunction

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] k,
                          input int hold, input string tag);
        logic [18:0] e;
        int          lat;
        e = model(o, a, b, k);
`ifdef ALU_BARREL_SHIFT_EN
        lat = 0;
`else
        lat = (o[2] && (k != 4'd0)) ? int'(k) : 0;
`endif
        check_eq({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op = o; Data1 = a; Data2 = b; imm = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check_eq({tag, "_busy_out_valid"}, 32'(out_valid), 32'd0);
            check_eq({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_Out"}, 32'(Out), 32'(e[15:0]));
        check_eq({tag, "_flag"}, 32'(flag), 32'(e[18:16]));
        // A competing offer while the result is held must be ignored,
        // including in the cycle where out_ready is accepted.
        in_valid = 1'b1; op = 3'($urandom); Data1 = 16'($urandom);
        Data2 = 16'($urandom); imm = 4'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_Out"}, 32'({flag, Out}), 32'(e));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_ack_Out_held"}, 32'({flag, Out}), 32'(e));
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       pick_operand = 16'h0000;
            1:       pick_operand = 16'h8000;
            2:       pick_operand = 16'h7FFF;
            3:       pick_operand = 16'hFFFF;
            default: pick_operand = 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Data1 = '0; Data2 = '0; op = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        check_eq("reset_Out", 32'(Out), 32'd0);
        check_eq("reset_flag", 32'(flag), 32'd0);

        run_op(3'd0, 16'd3,    16'hFFFD, 4'd0, 0, "add_zero");
        check_eq("add_zero_flag_const", 32'(flag), 32'b100);
        run_op(3'd1, 16'h8000, 16'h0001, 4'd0, 1, "sub_ovf");
        check_eq("sub_ovf_const", 32'({flag, Out}), 32'({3'b010, 16'h7FFF}));
        run_op(3'd2, 16'hAF05, 16'h50FA, 4'd0, 0, "and_zero");
        run_op(3'd3, 16'h0000, 16'h0080, 4'd0, 0, "or");
        run_op(3'd6, 16'h8000, 16'h0000, 4'd4, 0, "sra4");
        check_eq("sra4_const", 32'({flag, Out}), 32'({3'b001, 16'hF800}));
        run_op(3'd7, 16'h0001, 16'h0000, 4'd1, 3, "ror1");
        check_eq("ror1_const", 32'(Out), 32'h8000);
        run_op(3'd7, 16'h1234, 16'h0000, 4'd0, 0, "ror0");
        run_op(3'd4, 16'hFFFF, 16'h0000, 4'd15, 0, "sll15");

        // Reset during the third shift cycle (or during DONE in the barrel build)
        run_op(3'd3, 16'h00F0, 16'h0F00, 4'd0, 0, "pre_rst");
        op = 3'd4; Data1 = 16'h0001; imm = 4'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_Out", 32'(Out), 32'd0);
        check_eq("midrst_flag", 32'(flag), 32'd0);
        @(posedge clk); #1;
        check_eq("midrst_stays_idle", 32'({out_valid, in_ready}), 32'b01);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] ro;
            ro = 3'($urandom);
            run_op(ro, pick_operand(), pick_operand(), 4'($urandom),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_alu_seq
`default_nettype wire
